// File: rtl/interleaver_commutator.sv
// rtl/interleaver_commutator.sv - registered round-robin 1-to-N commutator with branch-0 sync realignment
// Optional sync misalignment flag: INTERLEAVER_COMMUTATOR_SYNC_CHECK_EN
module interleaver_commutator #(
  parameter int W            = 8,
  parameter int N            = 12,
  parameter int SELW         = 4,
  parameter int HOLD_OUTPUTS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      in_data,
  input  logic              in_valid,
  input  logic              in_sync,
  output logic              in_ready,
  output logic [N*W-1:0]    data_out,
  output logic [N-1:0]      out_valid,
  output logic [SELW-1:0]   out_branch,
  input  logic              out_ready,
  output logic              sync_err
);

  logic [N*W-1:0]  data_q, data_d;
  logic [N-1:0]    valid_q, valid_d;
  logic [SELW-1:0] branch_q, branch_d;
  logic [SELW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] tgt;
  logic            accept;

  assign in_ready = (valid_q == '0) | out_ready;
  assign accept   = in_valid & in_ready;
  assign tgt      = in_sync ? '0 : cnt_q;

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    branch_d = branch_q;
    cnt_d    = cnt_q;
    if (accept) begin
      // A new beat replaces a consumed one in the same edge, so no bubble.
      for (int k = 0; k < N; k++) begin
        if (tgt == SELW'(k)) begin
          data_d[k*W +: W] = in_data;
          valid_d[k]       = 1'b1;
        end else begin
          valid_d[k] = 1'b0;
          if (HOLD_OUTPUTS == 0) data_d[k*W +: W] = '0;
        end
      end
      branch_d = tgt;
      cnt_d    = (tgt == SELW'(N - 1)) ? '0 : tgt + SELW'(1);
    end else if (out_ready) begin
      valid_d = '0;
      if (HOLD_OUTPUTS == 0) data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      valid_q  <= '0;
      branch_q <= '0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      branch_q <= branch_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_out   = data_q;
  assign out_valid  = valid_q;
  assign out_branch = branch_q;

`ifdef INTERLEAVER_COMMUTATOR_SYNC_CHECK_EN
  logic sync_err_q, sync_err_d;

  // The flag travels with its beat: it holds through a stall and clears on consume.
  always_comb begin
    sync_err_d = sync_err_q;
    if (accept) begin
      sync_err_d = in_sync & (cnt_q != '0);
    end else if (out_ready) begin
      sync_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_interleaver_commutator.sv
// tb/tb_interleaver_commutator.sv - scoreboard bench: N=12 zeroing, N=12 holding and N=1 instances on one stream
module tb_interleaver_commutator;

`ifdef INTERLEAVER_COMMUTATOR_SYNC_CHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_sync = 1'b0;
  logic        out_ready = 1'b1;

  logic        rdy_a, rdy_b, rdy_c;
  logic [95:0] do_a, do_b;
  logic [11:0] ov_a, ov_b;
  logic [3:0]  br_a, br_b;
  logic        se_a, se_b, se_c;
  logic [7:0]  do_c;
  logic [0:0]  ov_c, br_c;

  always #5 clk = ~clk;

  interleaver_commutator #(.W(8), .N(12), .SELW(4), .HOLD_OUTPUTS(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
    .in_ready(rdy_a), .data_out(do_a), .out_valid(ov_a), .out_branch(br_a),
    .out_ready(out_ready), .sync_err(se_a));

  interleaver_commutator #(.W(8), .N(12), .SELW(4), .HOLD_OUTPUTS(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
    .in_ready(rdy_b), .data_out(do_b), .out_valid(ov_b), .out_branch(br_b),
    .out_ready(out_ready), .sync_err(se_b));

  interleaver_commutator #(.W(8), .N(1), .SELW(1), .HOLD_OUTPUTS(0)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
    .in_ready(rdy_c), .data_out(do_c), .out_valid(ov_c), .out_branch(br_c),
    .out_ready(out_ready), .sync_err(se_c));

  typedef struct {
    int          br;
    logic [95:0] bus;
    logic        serr;
  } beat_t;

  beat_t       q_a[$];
  logic [95:0] q_b[$];
  logic [7:0]  q_c[$];
  int          cnt_m;
  logic [95:0] mirror;
  logic        pend;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tgt_of(int c, logic s);
    return s ? 0 : c;
  endfunction

  function automatic logic [95:0] put(logic [95:0] base, int t, logic [7:0] d);
    logic [95:0] r;
    r = base;
    r[t*8 +: 8] = d;
    return r;
  endfunction

  function automatic beat_t mk(int t, logic [7:0] d, logic e);
    beat_t b;
    b.br   = t;
    b.bus  = put(96'h0, t, d);
    b.serr = e;
    return b;
  endfunction

  function automatic logic [11:0] onehot(int b);
    logic [11:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  // Reference model: a word is taken when no beat is pending or the pending one is consumed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_m  <= 0;
      mirror <= '0;
      pend   <= 1'b0;
      q_a.delete();
      q_b.delete();
      q_c.delete();
    end else if (in_valid && (!pend || out_ready)) begin
      q_a.push_back(mk(tgt_of(cnt_m, in_sync), in_data, SC && in_sync && (cnt_m != 0)));
      q_b.push_back(put(mirror, tgt_of(cnt_m, in_sync), in_data));
      q_c.push_back(in_data);
      mirror <= put(mirror, tgt_of(cnt_m, in_sync), in_data);
      cnt_m  <= (tgt_of(cnt_m, in_sync) + 1) % 12;
      pend   <= 1'b1;
    end else if (out_ready) begin
      pend <= 1'b0;
    end
  end

  // Monitor: compares the presented beat against the queue head; pops on consume.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ov_a", ov_a, 0);
      chk("rst_do_a", do_a, 0);
      chk("rst_br_a", br_a, 0);
      chk("rst_do_b", do_b, 0);
      chk("rst_ov_c", ov_c, 0);
    end else begin
      chk("in_ready_a", rdy_a, (q_a.size() == 0) || out_ready);
      chk("in_ready_c", rdy_c, (q_a.size() == 0) || out_ready);
      if (q_a.size() != 0) begin
        chk("out_valid_a", ov_a, onehot(q_a[0].br));
        chk("out_branch_a", br_a, q_a[0].br);
        chk("data_out_a", do_a, q_a[0].bus);
        chk("sync_err_a", se_a, q_a[0].serr);
        chk("out_valid_b", ov_b, onehot(q_a[0].br));
        chk("data_out_b", do_b, q_b[0]);
        chk("sync_err_b", se_b, q_a[0].serr);
        chk("out_valid_c", ov_c, 1);
        chk("out_branch_c", br_c, 0);
        chk("data_out_c", do_c, q_c[0]);
        if (out_ready) begin
          void'(q_a.pop_front());
          void'(q_b.pop_front());
          void'(q_c.pop_front());
        end
      end else begin
        chk("idle_valid_a", ov_a, 0);
        chk("idle_data_a", do_a, 0);
        chk("idle_sync_err_a", se_a, 0);
        chk("idle_valid_b", ov_b, 0);
        chk("idle_hold_b", do_b, mirror);
        chk("idle_valid_c", ov_c, 0);
        chk("idle_data_c", do_c, 0);
      end
      chk("sync_err_c", se_c, 0);
    end
  end

  task automatic drive(logic v, logic [7:0] d, logic s, logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_sync   = s;
    out_ready = r;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 8'h00, 0, 1);

    for (int i = 0; i < 24; i++) drive(1, 8'(i), i == 0, 1);
    drive(0, 8'h00, 0, 1);

    drive(1, 8'h01, 1, 1);
    drive(1, 8'h02, 0, 1);
    drive(1, 8'h03, 0, 1);
    drive(1, 8'hA5, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 8'h5A, 0, 0);
    drive(1, 8'h5A, 0, 1);
    drive(0, 8'h00, 0, 1);

    for (int i = 0; i < 5; i++) drive(1, 8'h60 + 8'(i), i == 0, 1);
    drive(1, 8'h47, 1, 1);
    drive(1, 8'h48, 0, 1);
    drive(0, 8'h00, 0, 1);

    drive(1, 8'h11, 1, 1);
    drive(1, 8'h22, 0, 1);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 1);

    for (int i = 0; i < 300; i++)
      drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0, ($urandom % 4) != 0);
    drive(0, 8'h00, 0, 1);

    drive(1, 8'h30, 1, 1);
    for (int i = 0; i < 6; i++) drive(1, 8'h31 + 8'(i), 0, 1);
    drive(0, 8'h00, 0, 0);
    @(posedge clk);
    #3;
    chk("pre_rst_valid", ov_a, 12'h040);
    rst = 1'b1;
    #1;
    chk("async_rst_valid_a", ov_a, 0);
    chk("async_rst_data_a", do_a, 0);
    chk("async_rst_branch_a", br_a, 0);
    chk("async_rst_data_b", do_b, 0);
    chk("async_rst_valid_c", ov_c, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 8'h99, 0, 1);
    drive(0, 8'h00, 0, 1);
    repeat (3) drive(0, 8'h00, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interleaver_commutator.md
Name: interleaver_commutator

Overview:
- Registered, parametrised 1-to-N commutator for the convolutional interleaver front end.
- Takes a byte stream with a valid/ready handshake and steers each accepted word to the next branch in round-robin order, using an internal branch counter that wraps.
- A sync input realigns the counter to branch 0.
- Feeds the N branch delay lines (FIFO/shift stages) downstream through a flat data bus and a one-hot valid vector.

Parameters:
- W, 8, data word width in bits.
- N, 12, number of branches (N >= 1).
- SELW, 4, width of the branch index; must satisfy 2**SELW >= N.
- HOLD_OUTPUTS, 0, selects what non-addressed branch slices show:
  - 0: non-addressed slices are driven to zero.
  - 1: non-addressed slices hold their last written value.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  W  input word.
- in_valid  input  1  input word valid.
- in_sync  input  1  qualifies in_data as a packet sync word; sampled only on accept.
- in_ready  output  1  block can accept a word this cycle.
- data_out  output  N*W  branch k occupies bits [k*W +: W].
- out_valid  output  N  one-hot; bit k set means data_out slice k holds a new word.
- out_branch  output  SELW  index of the branch written by the current output beat.
- out_ready  input  1  downstream consumes the current output beat.
- sync_err  output  1  sync misalignment pulse (see Optional Feature).

Behaviour:
- Reset (async assert, synchronous release on clk):
  - data_out = 0, out_valid = 0, out_branch = 0, sync_err = 0.
  - Internal branch counter cnt = 0.
  - Reset mid-operation discards any pending beat immediately.
- Handshake:
  - in_ready = (out_valid == 0) | out_ready. This is combinational from registered state and out_ready.
  - accept = in_valid & in_ready.
  - The output beat is held stable while out_valid != 0 and out_ready = 0.
- Target branch on accept: tgt = in_sync ? 0 : cnt.
- On accept, registered, latency 1 cycle:
  - data_out slice tgt <= in_data.
  - out_valid <= one-hot(tgt).
  - out_branch <= tgt.
  - cnt <= (tgt == N-1) ? 0 : tgt + 1.
  - If HOLD_OUTPUTS = 0, all other slices <= 0 in the same edge. If 1, other slices are unchanged.
- No accept and out_ready = 1:
  - out_valid <= 0.
  - If HOLD_OUTPUTS = 0, data_out <= 0.
  - out_branch and cnt are unchanged.
- No accept and out_ready = 0: all state is held.
- Simultaneous consume and accept: the new beat replaces the old one in the same edge, with no bubble. This gives full throughput of 1 word per clk.
- Wrap-around:
  - cnt never takes a value >= N.
  - For N = 1, cnt stays 0 permanently.
  - Counter arithmetic is done in SELW bits; compare against N-1 explicitly. Do not rely on natural overflow.
- in_sync without in_valid, or while stalled, has no effect.
- Consecutive in_sync beats each target branch 0.
- out_valid is never more than one-hot.

Optional Feature:
- Macro: INTERLEAVER_COMMUTATOR_SYNC_CHECK_EN.
- Defined:
  - On an accept with in_sync = 1 and cnt != 0, sync_err is set to 1 for exactly one cycle, aligned with that output beat.
  - If the beat stalls, sync_err holds with the beat and clears with it.
  - Realignment to branch 0 still occurs.
- Undefined: sync_err is tied to 0 and no check logic is built.
- Datapath behaviour is identical in both builds.

Test Plan:
- Round-robin, N=12, W=8, out_ready = 1: stream bytes 0x00..0x17 with in_sync only on 0x00.
  - Required: out_valid walks bit 0..11 twice; slice k = 0x0k, then 0x0C+k.
  - Required: out_branch = 0..11 twice; cnt wraps to 0 after branch 11; no sync_err.
- Backpressure: send 0xA5 to branch 3, then hold out_ready = 0 for 4 cycles with in_valid = 1 and data 0x5A.
  - Required: in_ready = 0; out_valid = 0x008 and slice 3 = 0xA5 stable throughout.
  - Required: on out_ready = 1, 0x5A is accepted the same cycle and appears next cycle on branch 4.
- Mid-frame sync (macro defined): after 5 words, assert in_sync with 0x47.
  - Required: 0x47 lands on branch 0, out_valid = 0x001.
  - Required: sync_err = 1 for one cycle; the next word goes to branch 1.
- HOLD_OUTPUTS: write 0x11 to branch 0, then 0x22 to branch 1.
  - HOLD_OUTPUTS = 1: slice 0 stays 0x11.
  - HOLD_OUTPUTS = 0: slice 0 = 0x00.
  - Idle with out_ready = 1: HOLD_OUTPUTS = 0 gives data_out = 0 and out_valid = 0.
- Async reset mid-stream: assert rst between clock edges while out_valid = 0x040.
  - Required: all outputs are 0 immediately.
  - Required: the first word after release goes to branch 0 without in_sync.
- Edge config N=1, SELW=1: 3 words with in_sync = 0.
  - Required: all land on branch 0; out_valid = 1 each beat; out_branch stays 0.
